// File: rtl/alu_sequencer_if.sv
// Bundles the control-unit request/response handshake and the ALU drive/return
// lines of the ALU sequencer. The sequencer connects through slave; the control
// side and the ALU connect through master.
interface alu_sequencer_if #(
    parameter int OP_W = 3
);
    logic            start;
    logic [OP_W-1:0] op;
    logic [7:0]      opa;
    logic [7:0]      opb;
    logic            dst_sel;
    logic            busy;
    logic            done;
    logic            err;
    logic [7:0]      result_hi;
    logic [7:0]      result_lo;
    logic [7:0]      alu_x;
    logic [7:0]      alu_y;
    logic [1:0]      alu_op;
    logic            alu_en;
    logic            alu_rs;
    logic [7:0]      alu_r;
    logic [7:0]      alu_s;

    modport slave (
        input  start, op, opa, opb, dst_sel, alu_r, alu_s,
        output busy, done, err, result_hi, result_lo,
               alu_x, alu_y, alu_op, alu_en, alu_rs
    );

    modport master (
        output start, op, opa, opb, dst_sel, alu_r, alu_s,
        input  busy, done, err, result_hi, result_lo,
               alu_x, alu_y, alu_op, alu_en, alu_rs
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences the 8-bit ALU for the control unit: one operation per start/done
// handshake. ADD/SUB/EQL8/EQL5 take a single ALU pass; MUL is an unsigned 8x8
// shift-add multiply built from MUL_ITERS ALU add passes, with the add carry
// recovered by comparing the wrapped sum against the addend.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold, alu_en low
// ISSUE   | ALU driven with operands, alu_en high
// CAPTURE | ALU drive held; ALU result sampled at the closing edge
// DONE    | one-cycle done (and err for an illegal op); results stable
module alu_sequencer #(
    parameter int MUL_ITERS = 8,
    parameter int OP_W      = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t     state;
    logic       is_mul;
    logic [7:0] opa_q;
    logic [7:0] acc_hi;
    logic [7:0] acc_lo;
    logic [2:0] iter;

    logic [7:0] sample;
    logic       carry;
    logic [7:0] nxt_hi;
    logic [7:0] nxt_lo;
    logic       last_pass;

    // ALU sample and next multiply accumulator ({carry,sum,acc_lo} shifted right by one)
    always_comb begin
        sample    = bus.alu_rs ? bus.alu_s : bus.alu_r;
        carry     = (sample < acc_hi);
        nxt_hi    = {carry, sample[7:1]};
        nxt_lo    = {sample[0], acc_lo[7:1]};
        last_pass = (iter == 3'(MUL_ITERS - 1));
    end

    // Sequencer FSM; every output is registered and set on the edge entering its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            is_mul        <= 1'b0;
            opa_q         <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            iter          <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.result_hi <= '0;
            bus.result_lo <= '0;
            bus.alu_x     <= '0;
            bus.alu_y     <= '0;
            bus.alu_op    <= '0;
            bus.alu_en    <= 1'b0;
            bus.alu_rs    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy      <= 1'b1;
                        bus.result_hi <= '0;
                        bus.result_lo <= '0;
                        if (bus.op >= OP_W'(5)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else if (bus.op == OP_W'(4)) begin
                            state      <= ISSUE;
                            is_mul     <= 1'b1;
                            opa_q      <= bus.opa;
                            acc_hi     <= '0;
                            acc_lo     <= bus.opb;
                            iter       <= '0;
                            bus.alu_en <= 1'b1;
                            bus.alu_x  <= '0;
                            bus.alu_y  <= bus.opb[0] ? bus.opa : 8'd0;
                            bus.alu_op <= 2'd0;
                            bus.alu_rs <= 1'b0;
                        end else begin
                            state      <= ISSUE;
                            is_mul     <= 1'b0;
                            bus.alu_en <= 1'b1;
                            bus.alu_x  <= bus.opa;
                            bus.alu_y  <= bus.opb;
                            bus.alu_op <= bus.op[1:0];
                            bus.alu_rs <= bus.dst_sel;
                        end
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (!is_mul) begin
                        bus.result_lo <= sample;
                        bus.result_hi <= '0;
                        bus.alu_en    <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        iter   <= iter + 3'd1;
                        if (last_pass) begin
                            bus.result_hi <= nxt_hi;
                            bus.result_lo <= nxt_lo;
                            bus.alu_en    <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= DONE;
                        end else begin
                            bus.alu_x <= nxt_hi;
                            bus.alu_y <= nxt_lo[0] ? opa_q : 8'd0;
                            state     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a registered behavioural ALU answers
// the sequencer, and each operation is compared with results, latency and
// ALU-pass counts computed arithmetically from the operation definitions.
module tb_alu_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    alu_sequencer_if #(.OP_W(3)) bus ();

    alu_sequencer #(.MUL_ITERS(8), .OP_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: computes on x/y while enabled and registers into r or s
    function automatic logic [7:0] alu_math(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        case (m)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return (x == y) ? 8'd1 : 8'd0;
            default: return (x[4:0] == y[4:0]) ? 8'd1 : 8'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_r <= '0;
            bus.alu_s <= '0;
        end else if (bus.alu_en) begin
            if (bus.alu_rs) bus.alu_s <= alu_math(bus.alu_op, bus.alu_x, bus.alu_y);
            else            bus.alu_r <= alu_math(bus.alu_op, bus.alu_x, bus.alu_y);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: {err, result_hi, result_lo}
    function automatic logic [16:0] ref_result(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        case (o)
            3'd0: return {9'd0, 8'((a + b) % 256)};
            3'd1: return {9'd0, 8'((256 + a - b) % 256)};
            3'd2: return (a == b) ? 17'd1 : 17'd0;
            3'd3: return ((a % 32) == (b % 32)) ? 17'd1 : 17'd0;
            3'd4: begin
                p = a * b;
                return {1'b0, 16'(p)};
            end
            default: return 17'h10000;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o);
        return (o == 3'd4) ? 17 : (o > 3'd4) ? 1 : 3;
    endfunction

    function automatic int ref_en_cycles(input logic [2:0] o);
        return (o == 3'd4) ? 16 : (o > 3'd4) ? 0 : 2;
    endfunction

    // Called on the first negedge after accept; returns cycles to done (-1 on timeout)
    task automatic wait_done(output int lat, output int en_cnt, output bit drive_ok,
                             input logic [1:0] exp_op, input logic exp_rs,
                             input logic [7:0] exp_x, input logic [7:0] exp_y, input bit chk_xy);
        lat      = 1;
        en_cnt   = 0;
        drive_ok = 1'b1;
        while (!bus.done && lat < 40) begin
            if (bus.alu_en) begin
                en_cnt++;
                if (bus.alu_op !== exp_op || bus.alu_rs !== exp_rs) drive_ok = 1'b0;
                if (chk_xy && (bus.alu_x !== exp_x || bus.alu_y !== exp_y)) drive_ok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (!bus.done) lat = -1;
        else if (bus.alu_en) drive_ok = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic d);
        int         lat;
        int         en_cnt;
        bit         ok;
        bit         mul;
        logic [16:0] exp;
        mul = (o == 3'd4);
        exp = ref_result(o, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b; bus.dst_sel = d;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = 3'($urandom);
        bus.opa     = 8'($urandom);
        bus.opb     = 8'($urandom);
        bus.dst_sel = 1'($urandom);
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        wait_done(lat, en_cnt, ok, mul ? 2'd0 : o[1:0], mul ? 1'b0 : d, a, b, !mul);
        check("latency", 64'(lat), 64'(ref_latency(o)));
        check("result", {47'd0, bus.err, bus.result_hi, bus.result_lo}, {47'd0, exp});
        check("alu_en_cycles", 64'(en_cnt), 64'(ref_en_cycles(o)));
        check("alu_drive", 64'(ok), 64'd1);
        @(negedge clk);
        check("done_one_cycle", {61'd0, bus.done, bus.err, bus.busy}, 64'd0);
        check("result_held", {48'd0, bus.result_hi, bus.result_lo}, {48'd0, exp[15:0]});
    endtask

    initial begin
        int  lat;
        int  en_cnt;
        int  dcnt;
        bit  ok;
        logic [2:0] ro;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0; bus.dst_sel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {25'd0, bus.busy, bus.done, bus.err, bus.result_hi, bus.result_lo,
               bus.alu_x, bus.alu_y, bus.alu_op, bus.alu_en, bus.alu_rs}, 64'd0);
        rst_n = 1'b1;

        run_op(3'd0, 8'h3C, 8'h14, 1'b0);
        run_op(3'd1, 8'h05, 8'h07, 1'b1);
        run_op(3'd3, 8'hE3, 8'h03, 1'b0);
        run_op(3'd2, 8'h5A, 8'h5A, 1'b1);
        run_op(3'd2, 8'h5A, 8'h5B, 1'b0);
        run_op(3'd4, 8'hFF, 8'hFF, 1'b0);
        run_op(3'd4, 8'h0D, 8'h0B, 1'b1);
        run_op(3'd4, 8'hA7, 8'h00, 1'b0);
        run_op(3'd4, 8'h00, 8'hC3, 1'b0);
        run_op(3'd6, 8'h12, 8'h34, 1'b1);
        run_op(3'd5, 8'hFF, 8'h01, 1'b0);
        run_op(3'd7, 8'h80, 8'h80, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ro = (i % 3 == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            run_op(ro, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // start held high through a MUL: one done, re-accept only from IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.opa = 8'h03; bus.opb = 8'h05; bus.dst_sel = 1'b0;
        @(negedge clk);
        wait_done(lat, en_cnt, ok, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("hold_latency", 64'(lat), 64'd17);
        check("hold_result", {48'd0, bus.result_hi, bus.result_lo}, 64'd15);
        @(negedge clk);
        check("hold_idle_gap", {62'd0, bus.done, bus.busy}, 64'd0);
        @(negedge clk);
        check("hold_reaccept", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(lat, en_cnt, ok, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("hold_second_latency", 64'(lat), 64'd17);
        check("hold_second_result", {48'd0, bus.result_hi, bus.result_lo}, 64'd15);
        @(negedge clk);

        // asynchronous reset in the middle of a MUL (ISSUE of iteration 4)
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.opa = 8'hB5; bus.opb = 8'h6D;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_mul_busy", {62'd0, bus.busy, bus.alu_en}, 64'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {25'd0, bus.busy, bus.done, bus.err, bus.result_hi, bus.result_lo,
               bus.alu_x, bus.alu_y, bus.alu_op, bus.alu_en, bus.alu_rs}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        check("no_done_after_abort", 64'(dcnt), 64'd0);
        run_op(3'd0, 8'h01, 8'h01, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequences the 8-bit arithmetic_logic datapath on behalf of the control unit.
- Accepts one operation per start/done handshake and drives the ALU operand, op, enable and destination lines.
- Samples the ALU result and returns it.
- Single-pass ops (add, sub, eql8, eql5) issue once. MUL performs an 8x8->16 unsigned shift-add multiply using 8 ALU add passes, with carry recovered internally.

Parameters:
- MUL_ITERS, 8, number of shift-add iterations for MUL (equals operand width; only 8 is supported).
- OP_W, 3, width of the op request field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  OP_W  0 ADD, 1 SUB, 2 EQL8, 3 EQL5, 4 MUL, 5-7 illegal.
- opa  input  8  operand A (x / multiplicand).
- opb  input  8  operand B (y / multiplier).
- dst_sel  input  1  ALU destination for single ops: 0 r, 1 s.
- busy  output  1  high from the cycle after accept through DONE.
- done  output  1  one-cycle pulse; result valid.
- err  output  1  pulses with done for illegal op.
- result_hi  output  8  MUL upper byte; 0 for other ops.
- result_lo  output  8  op result / MUL lower byte.
- alu_x  output  8  to ALU x.
- alu_y  output  8  to ALU y.
- alu_op  output  2  to ALU math_op (math enum encoding 0..3).
- alu_en  output  1  to ALU alu_en.
- alu_rs  output  1  to ALU alu_rs.
- alu_r  input  8  ALU r_out.
- alu_s  input  8  ALU s_out.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; internal accumulators 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: if start=1 at a rising edge, latch op, opa, opb and dst_sel, go to ISSUE.
  - MUL: acc_hi=0, acc_lo=opb, iter=0.
  - Illegal op: go directly to DONE with err=1, result 0.
- ISSUE: alu_en=1.
  - Single op: alu_x=opa, alu_y=opb, alu_op=op[1:0], alu_rs=dst_sel.
  - MUL: alu_x=acc_hi, alu_y=acc_lo[0]?opa:0, alu_op=0 (add), alu_rs=0.
  - Next state: CAPTURE.
- CAPTURE: same ALU drive held. At the edge, sample alu_s if alu_rs=1, else alu_r.
  - Single op: result_lo=sample, result_hi=0. Go to DONE.
  - MUL: carry=(sample < acc_hi) unsigned compare; {acc_hi,acc_lo} <= {carry,sample,acc_lo[7:1]}; iter+1.
  - MUL with iter=MUL_ITERS-1: load result_hi/lo from the updated accumulators, go to DONE. Otherwise go to ISSUE.
- DONE: done=1, busy=1 for exactly one cycle; alu_en=0; results held stable until the next accept. Next state: IDLE.
- alu_en=0 in IDLE and DONE; alu_x, alu_y and alu_op hold their last values there.
- Latency, counted from the accept edge to the cycle with done=1:
  - Single op: 3 cycles (ISSUE, CAPTURE, DONE).
  - MUL: 17 cycles (8 x ISSUE+CAPTURE, then DONE).
  - Illegal op: 1 cycle.
- Throughput: a new start is accepted in the first IDLE cycle after DONE. The minimum gap between dones is 4 cycles for single ops.
- start is ignored while busy; a start coinciding with done is ignored.
- Operand inputs may change after accept without effect.
- EQL8/EQL5 return the ALU flag in result_lo[0] (value 0 or 1).
- Arithmetic is modulo 2^8 for ADD/SUB. No overflow flag.

Test Plan:
- ADD: opa=8'h3C, opb=8'h14, dst_sel=0 -> alu_en high 2 cycles with alu_op=0, alu_rs=0; done on cycle 3; result_lo=8'h50, result_hi=0, err=0.
- SUB and EQL5: SUB opa=8'h05, opb=8'h07, dst_sel=1 -> alu_rs=1, result_lo=8'hFE. Then EQL5 opa=8'hE3, opb=8'h03 -> result_lo=8'h01. Both with 3-cycle latency.
- MUL: opa=8'hFF, opb=8'hFF -> exactly 8 ALU add passes; done on cycle 17; {result_hi,result_lo}=16'hFE01.
- MUL opa=8'h0D, opb=8'h0B -> 16'h008F. MUL with opb=0 -> 16'h0000, same 17-cycle latency.
- Illegal op=6 -> done and err pulse 1 cycle after accept; results 0; alu_en never asserted. Start held high during a MUL -> only one done; the second request is accepted after IDLE.
- rst_n pulled low mid-MUL (iter=4) asynchronously -> outputs 0 immediately, no done. After release, ADD 1+1 completes normally with result_lo=2.
